// File: rtl/mips_pkg.sv
// Shared IF-stage definitions: PC FSM states and default PC geometry.
package mips_pkg;

  localparam int SIZE_ADDR_PC = 32;
  localparam int PC_INCR = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle between the debug/hazard side (master) and the PC register (slave).
// Step-mode signals exist only when PC_STEP_EN is defined.
interface pc_fetch_ctrl_if #(
  parameter int SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC
);
  logic                    i_enable;
  logic                    i_stall;
  logic                    i_halt;
  logic [SIZE_ADDR_PC-1:0] i_next_pc;
  logic [SIZE_ADDR_PC-1:0] o_pc;
  logic [SIZE_ADDR_PC-1:0] o_pc4;
  logic                    o_valid;
  logic                    o_halted;
  logic                    o_misaligned;
`ifdef PC_STEP_EN
  logic                    i_step_mode;
  logic                    i_step;
`endif

  modport master (
    output i_enable, i_stall, i_halt, i_next_pc,
`ifdef PC_STEP_EN
    output i_step_mode, i_step,
`endif
    input  o_pc, o_pc4, o_valid, o_halted, o_misaligned
  );

  modport slave (
    input  i_enable, i_stall, i_halt, i_next_pc,
`ifdef PC_STEP_EN
    input  i_step_mode, i_step,
`endif
    output o_pc, o_pc4, o_valid, o_halted, o_misaligned
  );
endinterface

// File: rtl/pc_adder.sv
// Sequential-address adder: o_pc4 = i_pc + PC_INCR, wrapping modulo 2^SIZE_ADDR_PC.
module pc_adder #(
  parameter int SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC,
  parameter int PC_INCR      = mips_pkg::PC_INCR
) (
  input  logic [SIZE_ADDR_PC-1:0] i_pc,
  output logic [SIZE_ADDR_PC-1:0] o_pc4
);
  localparam logic [SIZE_ADDR_PC-1:0] INCR = SIZE_ADDR_PC'(PC_INCR);

  assign o_pc4 = i_pc + INCR;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with IDLE/RUN/HALTED fetch sequencing.
// Optional single-step gating is compiled in with PC_STEP_EN.
module pc_fetch_ctrl #(
  parameter int                      SIZE_ADDR_PC = mips_pkg::SIZE_ADDR_PC,
  parameter logic [SIZE_ADDR_PC-1:0] RESET_PC     = SIZE_ADDR_PC'(mips_pkg::RESET_PC),
  parameter int                      PC_INCR      = mips_pkg::PC_INCR
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pc_fetch_ctrl_if.slave  if_pc
);
  import mips_pkg::*;

  pc_state_t               r_state;
  logic [SIZE_ADDR_PC-1:0] r_pc;
  logic                    r_valid;
  logic                    r_halted;
  logic                    r_misaligned;
  logic [SIZE_ADDR_PC-1:0] w_pc4;
  logic                    w_step_ok;

`ifdef PC_STEP_EN
  assign w_step_ok = !if_pc.i_step_mode || if_pc.i_step;
`else
  assign w_step_ok = 1'b1;
`endif

  // Halt outranks disable, disable outranks stall, stall outranks the alignment check.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_valid      <= 1'b0;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (if_pc.i_enable) begin
            r_state <= RUN;
            r_valid <= 1'b1;
          end
        end
        RUN: begin
          if (if_pc.i_halt) begin
            r_state  <= HALTED;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
          end else if (!if_pc.i_enable) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end else if (!if_pc.i_stall) begin
            if (|if_pc.i_next_pc[1:0]) begin
              r_state      <= HALTED;
              r_valid      <= 1'b0;
              r_halted     <= 1'b1;
              r_misaligned <= 1'b1;
            end else if (w_step_ok) begin
              r_pc <= if_pc.i_next_pc;
            end
          end
        end
        HALTED: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  pc_adder #(
    .SIZE_ADDR_PC (SIZE_ADDR_PC),
    .PC_INCR      (PC_INCR)
  ) u_pc_adder (
    .i_pc  (r_pc),
    .o_pc4 (w_pc4)
  );

  assign if_pc.o_pc         = r_pc;
  assign if_pc.o_pc4        = w_pc4;
  // In step mode a fetch is only presented during the step pulse.
  assign if_pc.o_valid      = r_valid && w_step_ok;
  assign if_pc.o_halted     = r_halted;
  assign if_pc.o_misaligned = r_misaligned;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each vector pushes the outputs expected
// during the cycle it is applied; a negedge monitor pops and compares.
module tb_pc_fetch_ctrl;
  logic clk;
  logic rst_n;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  pc_fetch_ctrl_if #(.SIZE_ADDR_PC(32)) bus ();

  pc_fetch_ctrl #(.SIZE_ADDR_PC(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .if_pc   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc",         bus.o_pc,                 e.pc);
      chk("pc4",        bus.o_pc4,                e.pc4);
      chk("valid",      {31'd0, bus.o_valid},     {31'd0, e.valid});
      chk("halted",     {31'd0, bus.o_halted},    {31'd0, e.halted});
      chk("misaligned", {31'd0, bus.o_misaligned}, {31'd0, e.mis});
    end
  end

  task automatic push(input logic [31:0] pc, input logic v, input logic h, input logic m);
    exp_t e;
    e.pc     = pc;
    e.pc4    = pc + 32'd4;
    e.valid  = v;
    e.halted = h;
    e.mis    = m;
    q.push_back(e);
  endtask

  // Apply inputs for one cycle; expected values are what the DUT shows during that cycle.
  task automatic vec(input logic en, input logic st, input logic hl, input logic [31:0] nx,
                     input logic sm, input logic sp,
                     input logic [31:0] e_pc, input logic e_v, input logic e_h, input logic e_m);
    bus.i_enable  = en;
    bus.i_stall   = st;
    bus.i_halt    = hl;
    bus.i_next_pc = nx;
`ifdef PC_STEP_EN
    bus.i_step_mode = sm;
    bus.i_step      = sp;
`else
    if (sm || sp) $display("note: step inputs ignored without step support");
`endif
    push(e_pc, e_v, e_h, e_m);
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle: outputs must be at reset values before any edge.
  task automatic do_reset();
    bus.i_enable  = 1'b0;
    bus.i_stall   = 1'b0;
    bus.i_halt    = 1'b0;
    bus.i_next_pc = 32'h0;
`ifdef PC_STEP_EN
    bus.i_step_mode = 1'b0;
    bus.i_step      = 1'b0;
`endif
    rst_n = 1'b0;
    push(32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.i_enable  = 1'b0;
    bus.i_stall   = 1'b0;
    bus.i_halt    = 1'b0;
    bus.i_next_pc = 32'h0;
`ifdef PC_STEP_EN
    bus.i_step_mode = 1'b0;
    bus.i_step      = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Start and sequential fetch 0,4,8,12,16
    vec(0,0,0,32'h0,  0,0, 32'h0,  0,0,0);
    vec(1,0,0,32'h4,  0,0, 32'h0,  0,0,0);
    vec(1,0,0,32'h4,  0,0, 32'h0,  1,0,0);
    vec(1,0,0,32'h8,  0,0, 32'h4,  1,0,0);
    vec(1,0,0,32'hC,  0,0, 32'h8,  1,0,0);
    vec(1,0,0,32'h10, 0,0, 32'hC,  1,0,0);
    vec(1,0,0,32'h14, 0,0, 32'h10, 1,0,0);
    do_reset();

    // Stall three cycles at 8, redirect to 0x40, then halt together with stall
    vec(1,0,0,32'h4,  0,0, 32'h0,  0,0,0);
    vec(1,0,0,32'h4,  0,0, 32'h0,  1,0,0);
    vec(1,0,0,32'h8,  0,0, 32'h4,  1,0,0);
    vec(1,1,0,32'hC,  0,0, 32'h8,  1,0,0);
    vec(1,1,0,32'hC,  0,0, 32'h8,  1,0,0);
    vec(1,1,0,32'hC,  0,0, 32'h8,  1,0,0);
    vec(1,0,0,32'h40, 0,0, 32'h8,  1,0,0);
    vec(1,1,1,32'h44, 0,0, 32'h40, 1,0,0);
    vec(0,0,0,32'h44, 0,0, 32'h40, 0,1,0);
    vec(1,0,0,32'h80, 0,0, 32'h40, 0,1,0);
    vec(1,0,0,32'h6,  0,0, 32'h40, 0,1,0);
    do_reset();

    // Halt with enable dropped: halt wins
    vec(1,0,0,32'h4,  0,0, 32'h0,  0,0,0);
    vec(0,0,1,32'h4,  0,0, 32'h0,  1,0,0);
    vec(1,0,0,32'h4,  0,0, 32'h0,  0,1,0);
    do_reset();

    // Disable returns to IDLE, re-enable does not advance, then misaligned target
    vec(1,0,0,32'h4,  0,0, 32'h0,  0,0,0);
    vec(1,0,0,32'h4,  0,0, 32'h0,  1,0,0);
    vec(0,0,0,32'h8,  0,0, 32'h4,  1,0,0);
    vec(1,0,0,32'h8,  0,0, 32'h4,  0,0,0);
    vec(1,0,0,32'h8,  0,0, 32'h4,  1,0,0);
    vec(1,0,0,32'h6,  0,0, 32'h8,  1,0,0);
    vec(1,0,0,32'hC,  0,0, 32'h8,  0,1,1);
    vec(1,0,0,32'hC,  0,0, 32'h8,  0,1,1);
    do_reset();

    // Address wrap: o_pc4 of 0xFFFF_FFFC is 0
    vec(1,0,0,32'hFFFF_FFFC, 0,0, 32'h0,         0,0,0);
    vec(1,0,0,32'hFFFF_FFFC, 0,0, 32'h0,         1,0,0);
    vec(1,0,0,32'h0,         0,0, 32'hFFFF_FFFC, 1,0,0);
    vec(1,0,0,32'h4,         0,0, 32'h0,         1,0,0);

`ifdef PC_STEP_EN
    do_reset();
    vec(1,0,0,32'h4, 1,0, 32'h0, 0,0,0);
    begin
      logic [31:0] pc_m;
      pc_m = 32'h0;
      for (int i = 0; i < 10; i++) begin
        logic sp;
        sp = (i == 3) || (i == 7);
        vec(1,0,0,pc_m + 32'd4, 1,sp, pc_m, sp,0,0);
        if (sp) pc_m = pc_m + 32'd4;
      end
      vec(1,0,0,pc_m + 32'd4, 1,0, 32'h8, 0,0,0);
    end
`endif

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
